// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the single-cycle CPU: produces one-cycle step_en
// pulses from a debounced step button or a free-run divider, with halt tracking.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000
) (
    input  logic        clock100Mhz,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        run_sw,
    input  logic        halt,
    output logic        step_en,
    output logic [15:0] cycle_count,
    output logic [1:0]  state
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t            state_q, state_nx;
    logic              btn_p0, btn_s, run_p0, run_s;
    logic              btn_db, btn_db_p1, press;
    logic [DB_W-1:0]   db_cnt;
    logic [DIV_W-1:0]  div_q, div_nx;
    logic              step_nx;

    // Stage 0/1: two-flop synchronisers for the raw board inputs
    always_ff @(posedge clock100Mhz or posedge reset) begin
        if (reset) begin
            btn_p0 <= 1'b0;
            btn_s  <= 1'b0;
            run_p0 <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            btn_p0 <= btn_step;
            btn_s  <= btn_p0;
            run_p0 <= run_sw;
            run_s  <= run_p0;
        end
    end

    // Debounce: accept a new level only after it has differed for the full window
    always_ff @(posedge clock100Mhz or posedge reset) begin
        if (reset) begin
            btn_db    <= 1'b0;
            btn_db_p1 <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_db_p1 <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = btn_db & ~btn_db_p1;

    always_comb begin
        state_nx = state_q;
        div_nx   = '0;
        step_nx  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt)       state_nx = HALTED;
                else if (run_s) state_nx = RUN;
                else if (press) step_nx  = 1'b1;
            end
            RUN: begin
                if (halt) begin
                    state_nx = HALTED;
                end else if (!run_s) begin
                    state_nx = IDLE;
                end else if (div_q == DIV_LAST) begin
                    step_nx = 1'b1;
                end else begin
                    div_nx = div_q + DIV_W'(1);
                end
            end
            HALTED: begin
                if (!run_s && !halt) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage 2: registered FSM state, divider, pulse and step count
    always_ff @(posedge clock100Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            step_en     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_nx;
            div_q       <= div_nx;
            step_en     <= step_nx;
            cycle_count <= cycle_count + 16'(step_en);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller: table-driven scenarios, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_cpu_step_controller;

    localparam int DB  = 4;
    localparam int DIV = 5;

    logic        clk = 1'b0;
    logic        reset, btn_step, run_sw, halt;
    logic        step_en;
    logic [15:0] cycle_count;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
        .clock100Mhz(clk),
        .reset      (reset),
        .btn_step   (btn_step),
        .run_sw     (run_sw),
        .halt       (halt),
        .step_en    (step_en),
        .cycle_count(cycle_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    btn;
        bit    toggle;
        bit    run;
        bit    hlt;
        int    ncyc;
        int    exp_pulses;
        int    exp_first;   // 1-based cycle of first pulse, 0 = not checked
        int    exp_state;
        int    exp_count;
    } seg_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input seg_t s);
        int pulses = 0;
        int first = 0;
        for (int k = 1; k <= s.ncyc; k++) begin
            btn_step = s.toggle ? ((k % 2) == 1) : s.btn;
            run_sw   = s.run;
            halt     = s.hlt;
            tick();
            if (step_en) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check({s.name, "_pulses"}, pulses, s.exp_pulses);
        check({s.name, "_state"}, int'(state), s.exp_state);
        check({s.name, "_count"}, int'(cycle_count), s.exp_count);
        if (s.exp_first != 0) check({s.name, "_latency"}, first, s.exp_first);
    endtask

    // Behavioural reference: level histories and cycles-since-entry arithmetic
    bit m_b0, m_bs, m_r0, m_rs, m_db, m_dbp, m_step;
    int m_dis, m_mode, m_runlen, m_cnt;

    task automatic model_reset();
        {m_b0, m_bs, m_r0, m_rs, m_db, m_dbp, m_step} = '0;
        m_dis = 0; m_mode = 0; m_runlen = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit b, input bit r, input bit h);
        bit pr, nstep;
        pr = m_db && !m_dbp;
        nstep = 0;
        case (m_mode)
            0: if (h) m_mode = 2;
               else if (m_rs) begin m_mode = 1; m_runlen = 0; end
               else if (pr) nstep = 1;
            1: if (h) m_mode = 2;
               else if (!m_rs) m_mode = 0;
               else begin
                   m_runlen++;
                   if (m_runlen % DIV == 0) nstep = 1;
               end
            default: if (!m_rs && !h) m_mode = 0;
        endcase
        m_cnt  = (m_cnt + int'(m_step)) % 65536;
        m_step = nstep;
        m_dbp  = m_db;
        if (m_bs != m_db) begin
            m_dis++;
            if (m_dis == DB) begin m_db = m_bs; m_dis = 0; end
        end else begin
            m_dis = 0;
        end
        m_bs = m_b0; m_b0 = b;
        m_rs = m_r0; m_r0 = r;
    endtask

    seg_t segs[6];
    logic [15:0] wrap_exp[3];

    initial begin
        reset = 1'b1; btn_step = 1'b0; run_sw = 1'b0; halt = 1'b0;
        #1;
        check("reset_step_en", int'(step_en), 0);
        check("reset_count", int'(cycle_count), 0);
        check("reset_state", int'(state), 0);
        tick(); tick();
        reset = 1'b0;

        segs[0] = '{"bounce",  1'b0, 1'b1, 1'b0, 1'b0, 30, 0, 0, 0, 0};
        segs[1] = '{"settle",  1'b0, 1'b0, 1'b0, 1'b0,  6, 0, 0, 0, 0};
        segs[2] = '{"press",   1'b1, 1'b0, 1'b0, 1'b0, 20, 1, 7, 0, 1};
        segs[3] = '{"release", 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 1};
        segs[4] = '{"run",     1'b0, 1'b0, 1'b1, 1'b0, 52, 9, 8, 1, 10};
        segs[5] = '{"rundrop", 1'b0, 1'b0, 1'b0, 1'b0,  5, 1, 1, 0, 11};
        for (int i = 0; i < 6; i++) run_seg(segs[i]);

        // Halt raised exactly on the cycle the first run pulse is due
        begin
            int pulses = 0;
            run_sw = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                tick();
                if (step_en) pulses++;
            end
            check("halt_prepulses", pulses, 0);
            check("halt_prestate", int'(state), 1);
            halt = 1'b1;
            tick();
            check("halt_no_pulse", int'(step_en), 0);
            check("halt_state", int'(state), 2);
            check("halt_count", int'(cycle_count), 11);
            btn_step = 1'b1;
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (step_en) pulses++;
            end
            check("halt_press_ignored", pulses, 0);
            check("halt_held_state", int'(state), 2);
            btn_step = 1'b0; halt = 1'b0; run_sw = 1'b0;
            tick(); tick();
            check("halt_wait_sync", int'(state), 2);
            tick();
            check("halt_exit_state", int'(state), 0);
            for (int k = 0; k < 8; k++) tick();
            check("halt_exit_count", int'(cycle_count), 11);
        end

        // Counter wrap through free-run steps
        begin
            int idx = 0;
            bit prev = 0;
            wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001;
            force dut.cycle_count = 16'hFFFE;
            #1;
            release dut.cycle_count;
            check("wrap_preload", int'(cycle_count), 16'hFFFE);
            run_sw = 1'b1;
            for (int k = 0; k < 40 && idx < 3; k++) begin
                tick();
                if (prev) begin
                    check("wrap_count", int'(cycle_count), int'(wrap_exp[idx]));
                    idx++;
                end
                prev = step_en;
            end
            check("wrap_steps_seen", idx, 3);
        end

        // Asynchronous reset in the middle of a clock period while running
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_step_en", int'(step_en), 0);
        check("async_reset_count", int'(cycle_count), 0);
        check("async_reset_state", int'(state), 0);
        run_sw = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        model_step(btn_step, run_sw, halt);
        check("post_reset_step_en", int'(step_en), 0);

        // Randomized stimulus against the reference model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(5, 0) == 0) btn_step = ~btn_step;
            if ($urandom_range(59, 0) == 0) run_sw = ~run_sw;
            if (halt) begin
                if ($urandom_range(7, 0) == 0) halt = 1'b0;
            end else if ($urandom_range(49, 0) == 0) begin
                halt = 1'b1;
            end
            tick();
            model_step(btn_step, run_sw, halt);
            check("rand_step_en", int'(step_en), int'(m_step));
            check("rand_state", int'(state), m_mode);
            check("rand_count", int'(cycle_count), m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
